// File: rtl/l32_ling_mod_subtractor.sv
`default_nettype none
// l32_ling_mod_subtractor: pipelined (a - b) mod 2^32-1 using a cyclic Ling end-around-carry adder.
// Macro L32_SUB_MIDREG_EN adds a register after H2/Pr2 (latency 3 instead of 2).
module l32_ling_mod_subtractor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] diff,
  output logic        zero
);

  // Bit i of the result holds v[(i - k) mod 32]: every prefix index wraps around the word.
  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned k);
    logic [63:0] t;
    t = {v, v} << k;
    return t[63:32];
  endfunction

  logic advance;
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  logic        v0_q;
  logic [31:0] a0_q, b0_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      a0_q <= '0;
      b0_q <= '0;
    end else if (advance) begin
      v0_q <= in_valid;
      a0_q <= a;
      b0_q <= b;
    end
  end

  logic [31:0] g_d, p_d, x_d;
  assign g_d = a0_q & ~b0_q;
  assign p_d = a0_q | ~b0_q;
  assign x_d = a0_q ^ ~b0_q;

  logic        v1_q;
  logic [31:0] g1_q, p1_q, x1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      g1_q <= '0;
      p1_q <= '0;
      x1_q <= '0;
    end else if (advance) begin
      v1_q <= v0_q;
      g1_q <= g_d;
      p1_q <= p_d;
      x1_q <= x_d;
    end
  end

  // Ling pseudo-carries: H spans 2, 8, 32 bits; Pr is the propagate shifted down by one bit.
  logic [31:0] h1, pr1, h2, pr2;
  assign h1  = g1_q | rotl(g1_q, 1);
  assign pr1 = rotl(p1_q, 1) & rotl(p1_q, 2);
  assign h2  = h1
             | (pr1 & rotl(h1, 2))
             | (pr1 & rotl(pr1, 2) & rotl(h1, 4))
             | (pr1 & rotl(pr1, 2) & rotl(pr1, 4) & rotl(h1, 6));
  assign pr2 = pr1 & rotl(pr1, 2) & rotl(pr1, 4) & rotl(pr1, 6);

  logic        vm;
  logic [31:0] hm, prm, pm, xm;

`ifdef L32_SUB_MIDREG_EN
  logic        v2_q;
  logic [31:0] h2_q, pr2_q, p2_q, x2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q  <= 1'b0;
      h2_q  <= '0;
      pr2_q <= '0;
      p2_q  <= '0;
      x2_q  <= '0;
    end else if (advance) begin
      v2_q  <= v1_q;
      h2_q  <= h2;
      pr2_q <= pr2;
      p2_q  <= p1_q;
      x2_q  <= x1_q;
    end
  end

  assign vm  = v2_q;
  assign hm  = h2_q;
  assign prm = pr2_q;
  assign pm  = p2_q;
  assign xm  = x2_q;
`else
  assign vm  = v1_q;
  assign hm  = h2;
  assign prm = pr2;
  assign pm  = p1_q;
  assign xm  = x1_q;
`endif

  logic [31:0] h3, carry, diff_d;
  logic        zero_d;
  assign h3 = hm
            | (prm & rotl(hm, 8))
            | (prm & rotl(prm, 8) & rotl(hm, 16))
            | (prm & rotl(prm, 8) & rotl(prm, 16) & rotl(hm, 24));
  // A full-circle window carry is the end-around carry; no separate increment is needed.
  assign carry  = pm & h3;
  assign diff_d = xm ^ rotl(carry, 1);
  assign zero_d = (diff_d == 32'h0000_0000) | (&diff_d);

  logic        out_valid_q;
  logic [31:0] diff_q;
  logic        zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      zero_q      <= 1'b0;
    end else if (advance) begin
      out_valid_q <= vm;
      diff_q      <= diff_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_l32_ling_mod_subtractor.sv
`default_nettype none
// tb_l32_ling_mod_subtractor: vector table plus scoreboard bench for the one's-complement subtractor.
module tb_l32_ling_mod_subtractor;

`ifdef L32_SUB_MIDREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        zero;

  l32_ling_mod_subtractor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        z;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        z;
    int          edg;
    bit          lc;
  } sb_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          n_out  = 0;
  bit          lat_chk = 1'b0;
  bit          done    = 1'b0;
  logic [31:0] exp_d;
  logic        exp_z;
  sb_t         q[$];
  sb_t         it;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // The adder yields a true 0 only for a=0, b=all-ones; any other zero residue reads as 0xFFFFFFFF.
  function automatic logic [31:0] ref_diff(input logic [31:0] ra, input logic [31:0] rb);
    logic [63:0] m;
    m = ({32'd0, ra} + 64'h0000_0000_FFFF_FFFF - {32'd0, rb}) % 64'h0000_0000_FFFF_FFFF;
    if (m == 64'd0 && !(ra == 32'd0 && rb == 32'hFFFF_FFFF)) m = 64'h0000_0000_FFFF_FFFF;
    return m[31:0];
  endfunction

  function automatic logic [31:0] xs(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    t = t ^ (t << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got diff %h, want no output (t=%0t)", diff, $time);
        end else begin
          it = q.pop_front();
          n_out++;
          chk("diff", diff, it.d);
          chk("zero", {31'd0, zero}, {31'd0, it.z});
          if (it.lc) chk("latency", cyc - it.edg, LAT);
        end
      end else if (out_valid && !out_ready) begin
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        if (q.size() > 0) chk("stall_hold", diff, q[0].d);
      end
      if (in_valid && in_ready) q.push_back('{exp_d, exp_z, cyc + 1, lat_chk});
    end
  end

  task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic [31:0] ed, input logic ez);
    int n;
    n        = 0;
    a        = ta;
    b        = tb_;
    exp_d    = ed;
    exp_z    = ez;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stuck low, want high within 200 cycles");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  task automatic send_model(input logic [31:0] ta, input logic [31:0] tb_);
    logic [31:0] d;
    d = ref_diff(ta, tb_);
    send(ta, tb_, d, (d == 32'd0) || (d == 32'hFFFF_FFFF));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [12];
    logic [31:0] rs, ra, rb;
    int          n0;
    bit          saw;

    vecs[0]  = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0};
    vecs[1]  = '{32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFD, 1'b0};
    vecs[2]  = '{32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
    vecs[3]  = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
    vecs[4]  = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[5]  = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[6]  = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
    vecs[7]  = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    vecs[8]  = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
    vecs[10] = '{32'h0000_0007, 32'hFFFF_FFFF, 32'h0000_0007, 1'b0};
    vecs[11] = '{32'hAAAA_AAAA, 32'h5555_5555, 32'h5555_5555, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    a         = 32'h0000_0005;
    b         = 32'h0000_0003;
    exp_d     = '0;
    exp_z     = 1'b0;
    #2;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_diff", diff, 32'd0);
    chk("reset_zero", {31'd0, zero}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    lat_chk = 1'b1;
    for (int i = 0; i < 12; i++) send(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].z);
    drain();

    lat_chk = 1'b0;
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send_model(32'h1000_0000 + i * 32'h0101_0101, i * 3);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_count", n_out - n0, 8);

    send(32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0);
    send(32'h0000_0009, 32'h0000_0003, 32'h0000_0006, 1'b0);
    send(32'h0000_0010, 32'h0000_0001, 32'h0000_000F, 1'b0);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_diff", diff, 32'd0);
    chk("midrst_zero", {31'd0, zero}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    a        = 32'h0000_0001;
    b        = 32'h0000_0000;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    saw      = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    chk("post_reset_quiet", {31'd0, saw}, 32'd0);
    @(posedge clk);
    #1;

    lat_chk = 1'b1;
    rs = 32'h2545_F491;
    for (int i = 0; i < 1000; i++) begin
      rs = xs(rs);
      ra = rs;
      rs = xs(rs);
      rb = (i % 97 == 0) ? ra : rs;
      send_model(ra, rb);
    end
    drain();

    lat_chk = 1'b0;
    done    = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send_model($urandom, $urandom);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
